// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: collector states, command
// encodings and the decode of which operands a command consumes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // Arithmetic commands (MODE = 1)
    localparam int unsigned ARITH_ADD     = 0;
    localparam int unsigned ARITH_SUB     = 1;
    localparam int unsigned ARITH_ADD_CIN = 2;
    localparam int unsigned ARITH_SUB_CIN = 3;
    localparam int unsigned ARITH_INC_A   = 4;
    localparam int unsigned ARITH_DEC_A   = 5;
    localparam int unsigned ARITH_INC_B   = 6;
    localparam int unsigned ARITH_DEC_B   = 7;
    localparam int unsigned ARITH_CMP     = 8;
    localparam int unsigned ARITH_MUL_INC = 9;
    localparam int unsigned ARITH_MUL_SHL = 10;

    // Logical commands (MODE = 0)
    localparam int unsigned LOGIC_AND     = 0;
    localparam int unsigned LOGIC_NAND    = 1;
    localparam int unsigned LOGIC_OR      = 2;
    localparam int unsigned LOGIC_NOR     = 3;
    localparam int unsigned LOGIC_XOR     = 4;
    localparam int unsigned LOGIC_XNOR    = 5;
    localparam int unsigned LOGIC_NOT_A   = 6;
    localparam int unsigned LOGIC_NOT_B   = 7;
    localparam int unsigned LOGIC_SHR1_A  = 8;
    localparam int unsigned LOGIC_SHL1_A  = 9;
    localparam int unsigned LOGIC_SHR1_B  = 10;
    localparam int unsigned LOGIC_SHL1_B  = 11;
    localparam int unsigned LOGIC_ROL_A_B = 12;
    localparam int unsigned LOGIC_ROR_A_B = 13;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_A    = 2'b01;
    localparam logic [1:0] REQ_B    = 2'b10;
    localparam logic [1:0] REQ_AB   = 2'b11;

    // Unknown commands need nothing, so they issue at once and the ALU flags them.
    function automatic logic [1:0] req_ops(input logic mode, input int unsigned cmd);
        logic [1:0] req;
        req = REQ_NONE;
        if (mode) begin
            case (cmd)
                ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
                ARITH_CMP, ARITH_MUL_INC, ARITH_MUL_SHL: req = REQ_AB;
                ARITH_INC_A, ARITH_DEC_A:                req = REQ_A;
                ARITH_INC_B, ARITH_DEC_B:                req = REQ_B;
                default:                                 req = REQ_NONE;
            endcase
        end else begin
            case (cmd)
                LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR, LOGIC_XOR,
                LOGIC_XNOR, LOGIC_ROL_A_B, LOGIC_ROR_A_B:   req = REQ_AB;
                LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A:   req = REQ_A;
                LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B:   req = REQ_B;
                default:                                   req = REQ_NONE;
            endcase
        end
        return req;
    endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Counts clock-enabled wait cycles for a partially collected operation and
// flags when the allowed number has elapsed.
module alu_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Load starts at 1: the first beat's own cycle already counts as waited.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects OPA/OPB arriving on separate beats and presents one registered
// operation to the ALU over a valid/ready handshake, with a wait timeout.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = 8,
    parameter int unsigned CMD_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [1:0]           INP_VALID,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [OP_WIDTH-1:0]  OPA,
    input  logic [OP_WIDTH-1:0]  OPB,
    input  logic                 CIN,
    output logic                 IN_READY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [1:0]           OUT_INP_VALID,
    output logic                 OUT_MODE,
    output logic [CMD_WIDTH-1:0] OUT_CMD,
    output logic [OP_WIDTH-1:0]  OUT_OPA,
    output logic [OP_WIDTH-1:0]  OUT_OPB,
    output logic                 OUT_CIN,
    output logic                 OUT_TIMEOUT
);

    state_t     state;
    logic [1:0] req;
    logic [1:0] first_req;
    logic [1:0] merged;
    logic       idle_issue;
    logic       wait_done;
    logic       terminal;
    logic       cnt_load;
    logic       cnt_enable;

    always_comb begin
        first_req  = req_ops(MODE, 32'(CMD));
        merged     = OUT_INP_VALID | INP_VALID;
        // An empty beat in IDLE also issues, carrying INP_VALID = 00 to the ALU.
        idle_issue = (INP_VALID == 2'b00) || ((INP_VALID & first_req) == first_req);
        wait_done  = ((merged & req) == req);
        cnt_load   = CE && (state == IDLE) && !idle_issue;
        cnt_enable = CE && (state == WAIT) && !wait_done && !terminal;
    end

    alu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .clear   (RST),
        .load    (cnt_load),
        .enable  (cnt_enable),
        .terminal(terminal)
    );

    // OUT_* double as the collection registers, so they are only meaningful with OUT_VALID.
    always_ff @(posedge clk) begin
        if (RST) begin
            state         <= IDLE;
            req           <= REQ_NONE;
            IN_READY      <= 1'b1;
            OUT_VALID     <= 1'b0;
            OUT_INP_VALID <= '0;
            OUT_MODE      <= 1'b0;
            OUT_CMD       <= '0;
            OUT_OPA       <= '0;
            OUT_OPB       <= '0;
            OUT_CIN       <= 1'b0;
            OUT_TIMEOUT   <= 1'b0;
        end else if (CE) begin
            case (state)
                IDLE: begin
                    OUT_MODE      <= MODE;
                    OUT_CMD       <= CMD;
                    OUT_CIN       <= CIN;
                    OUT_INP_VALID <= INP_VALID;
                    OUT_OPA       <= INP_VALID[0] ? OPA : '0;
                    OUT_OPB       <= INP_VALID[1] ? OPB : '0;
                    OUT_TIMEOUT   <= 1'b0;
                    req           <= first_req;
                    if (idle_issue) begin
                        state     <= ISSUE;
                        OUT_VALID <= 1'b1;
                        IN_READY  <= 1'b0;
                    end else begin
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (INP_VALID[0]) OUT_OPA <= OPA;
                    if (INP_VALID[1]) OUT_OPB <= OPB;
                    OUT_INP_VALID <= merged;
                    if (wait_done) begin
                        state     <= ISSUE;
                        OUT_VALID <= 1'b1;
                        IN_READY  <= 1'b0;
                    end else if (terminal) begin
                        state       <= ISSUE;
                        OUT_VALID   <= 1'b1;
                        IN_READY    <= 1'b0;
                        OUT_TIMEOUT <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (OUT_READY) begin
                        state       <= IDLE;
                        OUT_VALID   <= 1'b0;
                        OUT_TIMEOUT <= 1'b0;
                        IN_READY    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_alu_operand_collector;

    localparam int unsigned OW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 16;

    logic          clk;
    logic          RST;
    logic          CE;
    logic [1:0]    INP_VALID;
    logic          MODE;
    logic [CW-1:0] CMD;
    logic [OW-1:0] OPA;
    logic [OW-1:0] OPB;
    logic          CIN;
    logic          IN_READY;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [1:0]    OUT_INP_VALID;
    logic          OUT_MODE;
    logic [CW-1:0] OUT_CMD;
    logic [OW-1:0] OUT_OPA;
    logic [OW-1:0] OUT_OPB;
    logic          OUT_CIN;
    logic          OUT_TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    alu_operand_collector #(
        .OP_WIDTH(OW),
        .CMD_WIDTH(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .CE           (CE),
        .INP_VALID    (INP_VALID),
        .MODE         (MODE),
        .CMD          (CMD),
        .OPA          (OPA),
        .OPB          (OPB),
        .CIN          (CIN),
        .IN_READY     (IN_READY),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_INP_VALID(OUT_INP_VALID),
        .OUT_MODE     (OUT_MODE),
        .OUT_CMD      (OUT_CMD),
        .OUT_OPA      (OUT_OPA),
        .OUT_OPB      (OUT_OPB),
        .OUT_CIN      (OUT_CIN),
        .OUT_TIMEOUT  (OUT_TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand requirement as bitmasks over the command number.
    function automatic bit [1:0] tb_req(input bit mode, input int unsigned cmd);
        bit [15:0] both;
        bit [15:0] only_a;
        bit [15:0] only_b;
        if (mode) begin
            both = 16'h070F; only_a = 16'h0030; only_b = 16'h00C0;
        end else begin
            both = 16'h303F; only_a = 16'h0340; only_b = 16'h0C80;
        end
        if (cmd > 15) return 2'b00;
        if (both[cmd[3:0]])   return 2'b11;
        if (only_a[cmd[3:0]]) return 2'b01;
        if (only_b[cmd[3:0]]) return 2'b10;
        return 2'b00;
    endfunction

    // Transaction-level model: one pending operation, its collected operands and its age.
    bit          m_valid, m_pend, m_to, m_mode, m_cin, m_rst_seen;
    bit [1:0]    m_have, m_need;
    bit [CW-1:0] m_cmd;
    bit [OW-1:0] m_opa, m_opb;
    int          m_age;

    always @(posedge clk) begin
        m_rst_seen = 1'b0;
        if (RST) begin
            m_valid = 0; m_pend = 0; m_to = 0; m_have = 0;
            m_mode = 0; m_cmd = 0; m_cin = 0; m_opa = 0; m_opb = 0;
            m_rst_seen = 1'b1;
        end else if (CE) begin
            if (m_valid) begin
                if (OUT_READY) begin
                    m_valid = 0;
                    m_to = 0;
                end
            end else if (!m_pend) begin
                m_mode = MODE; m_cmd = CMD; m_cin = CIN; m_have = INP_VALID;
                m_opa  = INP_VALID[0] ? OPA : '0;
                m_opb  = INP_VALID[1] ? OPB : '0;
                m_need = tb_req(MODE, 32'(CMD));
                m_age  = 0;
                m_to   = 0;
                if (INP_VALID == 2'b00 || (m_have & m_need) == m_need) m_valid = 1;
                else m_pend = 1;
            end else begin
                m_age++;
                if (INP_VALID[0]) m_opa = OPA;
                if (INP_VALID[1]) m_opb = OPB;
                m_have |= INP_VALID;
                if ((m_have & m_need) == m_need) begin
                    m_valid = 1; m_pend = 0;
                end else if (m_age == TO) begin
                    m_valid = 1; m_pend = 0; m_to = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_rst_seen) begin
                chk("rst.inp_valid", 32'(OUT_INP_VALID), 0);
                chk("rst.mode",      32'(OUT_MODE), 0);
                chk("rst.cmd",       32'(OUT_CMD), 0);
                chk("rst.opa",       32'(OUT_OPA), 0);
                chk("rst.opb",       32'(OUT_OPB), 0);
                chk("rst.cin",       32'(OUT_CIN), 0);
            end
            chk("out_valid", 32'(OUT_VALID), 32'(m_valid));
            chk("in_ready",  32'(IN_READY), 32'(!m_valid));
            if (m_valid) begin
                chk("out_inp_valid", 32'(OUT_INP_VALID), 32'(m_have));
                chk("out_mode",      32'(OUT_MODE), 32'(m_mode));
                chk("out_cmd",       32'(OUT_CMD), 32'(m_cmd));
                chk("out_opa",       32'(OUT_OPA), 32'(m_opa));
                chk("out_opb",       32'(OUT_OPB), 32'(m_opb));
                chk("out_cin",       32'(OUT_CIN), 32'(m_cin));
                chk("out_timeout",   32'(OUT_TIMEOUT), 32'(m_to));
            end else begin
                chk("out_timeout_idle", 32'(OUT_TIMEOUT), 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] iv, input logic mode, input logic [CW-1:0] cmd,
                        input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin);
        INP_VALID = iv; MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin;
    endtask

    task automatic expect_op(input string tag, input logic [1:0] iv, input logic mode,
                             input logic [CW-1:0] cmd, input logic [OW-1:0] a,
                             input logic [OW-1:0] b, input logic cin, input logic to);
        chk({tag, ".valid"},     32'(OUT_VALID), 1);
        chk({tag, ".in_ready"},  32'(IN_READY), 0);
        chk({tag, ".inp_valid"}, 32'(OUT_INP_VALID), 32'(iv));
        chk({tag, ".mode"},      32'(OUT_MODE), 32'(mode));
        chk({tag, ".cmd"},       32'(OUT_CMD), 32'(cmd));
        chk({tag, ".opa"},       32'(OUT_OPA), 32'(a));
        chk({tag, ".opb"},       32'(OUT_OPB), 32'(b));
        chk({tag, ".cin"},       32'(OUT_CIN), 32'(cin));
        chk({tag, ".timeout"},   32'(OUT_TIMEOUT), 32'(to));
    endtask

    // Leaves the collector in IDLE with CE low; bounded so a stuck DUT cannot hang the run.
    task automatic drain();
        bit done;
        done = 1'b0;
        CE = 1; OUT_READY = 1; INP_VALID = 2'b00;
        for (int i = 0; i < 40 && !done; i++) begin
            if (OUT_VALID) done = 1'b1;
            cyc();
        end
        CE = 0;
        chk("drain_reached_idle", 32'(done), 1);
    endtask

    initial begin
        RST = 1; CE = 0; OUT_READY = 1;
        beat(2'b00, 0, '0, '0, '0, 0);
        chk_en = 1;
        cyc();
        cyc();
        chk("reset.in_ready",  32'(IN_READY), 1);
        chk("reset.out_valid", 32'(OUT_VALID), 0);
        chk("reset.timeout",   32'(OUT_TIMEOUT), 0);
        RST = 0;

        // Both operands on one beat
        CE = 1;
        beat(2'b11, 1, 4'd0, 8'h12, 8'h34, 0);
        cyc();
        expect_op("both_one_beat", 2'b11, 1, 4'd0, 8'h12, 8'h34, 0, 0);
        drain();

        // Empty beat in IDLE issues an error op
        CE = 1;
        beat(2'b00, 1, 4'd1, 8'hFF, 8'hEE, 1);
        cyc();
        expect_op("empty_beat", 2'b00, 1, 4'd1, 8'h00, 8'h00, 1, 0);
        drain();

        // Split operands; later beat's MODE/CMD/CIN ignored
        CE = 1;
        beat(2'b01, 1, 4'd0, 8'hA5, 8'h00, 1);
        cyc();
        chk("split.wait_valid", 32'(OUT_VALID), 0);
        chk("split.wait_ready", 32'(IN_READY), 1);
        INP_VALID = 2'b00;
        cyc();
        cyc();
        beat(2'b10, 0, 4'd5, 8'h00, 8'h5A, 0);
        cyc();
        expect_op("split", 2'b11, 1, 4'd0, 8'hA5, 8'h5A, 1, 0);
        drain();

        // Timeout after exactly TO edges
        CE = 1; OUT_READY = 0;
        beat(2'b01, 0, 4'd12, 8'h3E, 8'h99, 0);
        cyc();
        INP_VALID = 2'b00;
        for (int e = 1; e < TO; e++) begin
            cyc();
            chk("timeout.early_valid", 32'(OUT_VALID), 0);
        end
        cyc();
        expect_op("timeout", 2'b01, 0, 4'd12, 8'h3E, 8'h00, 0, 1);
        drain();

        // Timeout with CE low for 4 edges, then output held while not accepted
        CE = 1; OUT_READY = 0;
        beat(2'b01, 0, 4'd12, 8'hC4, 8'h00, 1);
        cyc();
        INP_VALID = 2'b00;
        for (int e = 1; e <= 20; e++) begin
            CE = (e >= 6 && e <= 9) ? 1'b0 : 1'b1;
            cyc();
            if (e < 20) chk("ce_timeout.early_valid", 32'(OUT_VALID), 0);
        end
        expect_op("ce_timeout", 2'b01, 0, 4'd12, 8'hC4, 8'h00, 1, 1);
        for (int k = 0; k < 3; k++) begin
            beat(2'b11, 1, 4'd3, 8'h01, 8'h02, 0);
            cyc();
            expect_op("ce_timeout.hold", 2'b01, 0, 4'd12, 8'hC4, 8'h00, 1, 1);
        end
        CE = 0; OUT_READY = 1;
        cyc();
        expect_op("ce_low_no_handshake", 2'b01, 0, 4'd12, 8'hC4, 8'h00, 1, 1);
        CE = 1; INP_VALID = 2'b00;
        cyc();
        chk("handshake.valid_drop",   32'(OUT_VALID), 0);
        chk("handshake.timeout_drop", 32'(OUT_TIMEOUT), 0);
        CE = 0;

        // Completion on the terminal edge beats the timeout
        CE = 1; OUT_READY = 1;
        beat(2'b01, 0, 4'd12, 8'h71, 8'h00, 0);
        cyc();
        INP_VALID = 2'b00;
        for (int e = 1; e < TO; e++) cyc();
        beat(2'b10, 0, 4'd12, 8'h00, 8'h17, 0);
        cyc();
        expect_op("complete_at_terminal", 2'b11, 0, 4'd12, 8'h71, 8'h17, 0, 0);
        drain();

        // Single-operand and out-of-range commands issue immediately
        CE = 1;
        beat(2'b01, 1, 4'd4, 8'h40, 8'hBB, 1);
        cyc();
        expect_op("inc_a", 2'b01, 1, 4'd4, 8'h40, 8'h00, 1, 0);
        drain();
        CE = 1;
        beat(2'b11, 1, 4'd15, 8'h0F, 8'hF0, 0);
        cyc();
        expect_op("cmd15", 2'b11, 1, 4'd15, 8'h0F, 8'hF0, 0, 0);
        drain();

        // Reset mid-wait discards the stale operand
        CE = 1;
        beat(2'b01, 1, 4'd0, 8'h77, 8'h00, 0);
        cyc();
        INP_VALID = 2'b00;
        cyc();
        RST = 1;
        cyc();
        chk("rst_wait.valid",     32'(OUT_VALID), 0);
        chk("rst_wait.in_ready",  32'(IN_READY), 1);
        chk("rst_wait.inp_valid", 32'(OUT_INP_VALID), 0);
        RST = 0;
        beat(2'b10, 1, 4'd0, 8'h00, 8'h3C, 0);
        cyc();
        chk("rst_wait.new_wait", 32'(OUT_VALID), 0);
        beat(2'b01, 1, 4'd0, 8'h11, 8'h00, 0);
        cyc();
        expect_op("rst_wait.new_op", 2'b11, 1, 4'd0, 8'h11, 8'h3C, 0, 0);
        drain();

        // Randomized traffic: busy phase, then sparse beats to provoke timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                RST       = ($urandom_range(0, 299) == 0);
                CE        = ($urandom_range(0, 9) != 0);
                OUT_READY = ($urandom_range(0, 9) < 6);
                MODE      = 1'($urandom);
                CMD       = CW'($urandom);
                OPA       = OW'($urandom);
                OPB       = OW'($urandom);
                CIN       = 1'($urandom);
                if (ph == 0) INP_VALID = 2'($urandom);
                else         INP_VALID = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
                cyc();
            end
        end
        RST = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
